// File: rtl/face_report_packetizer.sv
// face_report_packetizer: queues face hits in a FIFO and serializes
// them, plus per-frame end-of-frame summaries, onto a byte stream.
// Ports: clock, reset_n (sync, active-low);
//   face_coords[0]=row, [1]=col, face_coords_ready, pyramid_number:
//   hit input, one-cycle pulse; frame_done: end-of-frame pulse;
//   tx_data/tx_valid/tx_ready: byte stream to the UART transmitter;
//   fifo_count: FIFO occupancy; overflow: sticky dropped-hit flag.
// Build option: define FACE_PKT_CHECKSUM_EN to append an XOR checksum
//   byte (face packet 7 bytes, EOF packet 3 bytes; else 6 and 2).
module face_report_packetizer #(
  parameter int FIFO_DEPTH = 16,
  parameter int COUNT_W    = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0][31:0]            face_coords,
  input  logic                        face_coords_ready,
  input  logic [3:0]                  pyramid_number,
  input  logic                        frame_done,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FACE_PKT_CHECKSUM_EN
  localparam int NB = 7;
  localparam int EB = 3;
`else
  localparam int NB = 6;
  localparam int EB = 2;
`endif
  localparam int SW = NB * 8;
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SEND_FACE,
    SEND_EOF
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       sr_q, sr_d;
  logic [2:0]          left_q, left_d;
  logic [35:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         cnt_q, cnt_d;
  logic                ovf_q;
  logic [COUNT_W-1:0]  hits_q, hits_inc;
  logic [COUNT_W-1:0]  eofc_q;
  logic                eofp_q;
  logic                pop, push, drop, eof_take;
  logic                full, empty, accept;
  logic [35:0]         entry_in, head;
  logic [7:0]          fb_pyr, ec8;
  logic [SW-1:0]       face_pkt, eof_pkt;

  // Coordinates above 16 bits clamp to all-ones instead of wrapping
  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (|v[31:16]) ? 16'hFFFF : v[15:0];
  endfunction

  assign entry_in = {pyramid_number,
                     sat16(face_coords[0]),
                     sat16(face_coords[1])};

  assign full   = (cnt_q == FULL_C);
  assign empty  = (cnt_q == '0);
  assign accept = tx_valid & tx_ready;

  // A full FIFO still takes a hit when the head leaves this cycle
  assign push = face_coords_ready & (~full | pop);
  assign drop = face_coords_ready & full & ~pop;

  assign hits_inc = (&hits_q) ? hits_q : hits_q + COUNT_W'(1);

  generate
    if (COUNT_W >= 8) begin : g_ec_wide
      assign ec8 = eofc_q[7:0];
    end else begin : g_ec_narrow
      assign ec8 = {{(8-COUNT_W){1'b0}}, eofc_q};
    end
  endgenerate

  assign head   = mem_q[rd_q];
  assign fb_pyr = {4'h0, head[35:32]};

`ifdef FACE_PKT_CHECKSUM_EN
  logic [7:0] face_ck;
  assign face_ck  = fb_pyr ^ head[31:24] ^ head[23:16]
                  ^ head[15:8] ^ head[7:0];
  assign face_pkt = {8'hA5, fb_pyr, head[31:0], face_ck};
  assign eof_pkt  = {8'h5A, ec8, ec8, 32'h0};
`else
  assign face_pkt = {8'hA5, fb_pyr, head[31:0]};
  assign eof_pkt  = {8'h5A, ec8, 32'h0};
`endif

  // Bytes leave from the top of the shift register; zeros shift in,
  // so tx_data reads 0 whenever no packet is loaded
  assign tx_valid = (state_q != IDLE);
  assign tx_data  = sr_q[SW-1 -: 8];
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    left_d   = left_q;
    pop      = 1'b0;
    eof_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sr_d    = face_pkt;
          left_d  = 3'(NB);
          state_d = SEND_FACE;
        end else if (eofp_q) begin
          eof_take = 1'b1;
          sr_d     = eof_pkt;
          left_d   = 3'(EB);
          state_d  = SEND_EOF;
        end
      end
      SEND_FACE, SEND_EOF: begin
        if (accept) begin
          sr_d   = sr_q << 8;
          left_d = left_q - 3'd1;
          if (left_q == 3'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_q] <= entry_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      left_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hits_q  <= '0;
      eofc_q  <= '0;
      eofp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
      // A hit on the frame_done cycle belongs to the ending frame
      if (frame_done) begin
        eofc_q <= face_coords_ready ? hits_inc : hits_q;
        hits_q <= '0;
      end else if (face_coords_ready) begin
        hits_q <= hits_inc;
      end
      if (frame_done) begin
        eofp_q <= 1'b1;
      end else if (eof_take) begin
        eofp_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_face_report_packetizer.sv
// tb_face_report_packetizer: scoreboard bench for the face packetizer.
// Expected byte streams come from a packet-level model of the format.
module tb_face_report_packetizer;

  logic            clock;
  logic            reset_n;
  logic [1:0][31:0] face_coords;
  logic            face_coords_ready;
  logic [3:0]      pyramid_number;
  logic            frame_done;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [4:0]      fifo_count;
  logic            overflow;

  face_report_packetizer #(
    .FIFO_DEPTH(16),
    .COUNT_W(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .face_coords(face_coords),
    .face_coords_ready(face_coords_ready),
    .pyramid_number(pyramid_number),
    .frame_done(frame_done),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int frame_hits = 0;
  int mode = 3;
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  task automatic exp_face(input logic [31:0] r, input logic [31:0] c,
                          input logic [3:0] p);
    logic [15:0] rs;
    logic [15:0] cs;
    rs = sat16(r);
    cs = sat16(c);
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'h0, p});
    exp_q.push_back(rs[15:8]);
    exp_q.push_back(rs[7:0]);
    exp_q.push_back(cs[15:8]);
    exp_q.push_back(cs[7:0]);
`ifdef FACE_PKT_CHECKSUM_EN
    exp_q.push_back({4'h0, p} ^ rs[15:8] ^ rs[7:0] ^ cs[15:8] ^ cs[7:0]);
`endif
  endtask

  task automatic exp_eof(input int n);
    logic [7:0] b;
    b = n[7:0];
    exp_q.push_back(8'h5A);
    exp_q.push_back(b);
`ifdef FACE_PKT_CHECKSUM_EN
    exp_q.push_back(b);
`endif
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic hit(input logic [31:0] r, input logic [31:0] c,
                     input logic [3:0] p, input bit fd, input bit keep);
    face_coords[0] = r;
    face_coords[1] = c;
    pyramid_number = p;
    face_coords_ready = 1'b1;
    frame_done = fd;
    if (keep) exp_face(r, c, p);
    frame_hits = (frame_hits >= 255) ? 255 : frame_hits + 1;
    if (fd) begin
      exp_eof(frame_hits);
      frame_hits = 0;
    end
    @(posedge clock); #1;
    face_coords_ready = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic fdone();
    frame_done = 1'b1;
    exp_eof(frame_hits);
    frame_hits = 0;
    @(posedge clock); #1;
    frame_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 4000) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_valid) begin
      errors++;
      $display("FAIL drain_%s: %0d bytes pending, tx_valid=%0b, required 0/0",
               tag, exp_q.size(), tx_valid);
    end
  endtask

  function automatic logic [31:0] rnd_coord();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = $urandom;
      1:       v = 32'h0000_FFFF;
      2:       v = 32'h0001_0000;
      default: v = $urandom_range(0, 65535);
    endcase
    return v;
  endfunction

  // ---------------- tx_ready driver ----------------
  always @(posedge clock) begin
    #1;
    case (mode)
      0: tx_ready = 1'b1;
      1: tx_ready = ~tx_ready;
      2: tx_ready = 1'($urandom_range(0, 1));
      3: tx_ready = 1'b0;
      default: ;
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  logic       stall_q = 1'b0;
  logic [7:0] stall_d = 8'h00;

  always @(negedge clock) begin
    if (!reset_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!tx_valid || tx_data !== stall_d) begin
          errors++;
          $display("FAIL hold: valid=%0b data=%0h, required 1/%0h",
                   tx_valid, tx_data, stall_d);
        end
      end
      if (tx_valid && tx_ready) begin
        logic [7:0] e;
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte: got %0h, required no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL byte: got %0h, required %0h", tx_data, e);
          end
        end
      end
      stall_q = tx_valid && !tx_ready;
      stall_d = tx_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    int k;
    reset_n = 1'b0;
    face_coords = '0;
    face_coords_ready = 1'b0;
    pyramid_number = 4'h0;
    frame_done = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    reset_n = 1'b1;
    mode = 0;
    idle(2);

    // single hit and first-byte latency
    hit(37, 112, 4'd3, 1'b0, 1'b1);
    chk("lat_valid_n", 32'(tx_valid), 0);
    chk("lat_count_n", 32'(fifo_count), 1);
    @(posedge clock); #1;
    chk("lat_valid_n1", 32'(tx_valid), 1);
    chk("lat_header", 32'(tx_data), 32'hA5);
    chk("lat_count_n1", 32'(fifo_count), 0);
    drain("single");

    // backpressure, ready toggling every cycle
    mode = 1;
    hit(1000, 2000, 4'd1, 1'b0, 1'b1);
    hit(32'h0000_FFFF, 32'h0001_0000, 4'd15, 1'b0, 1'b1);
    idle(3);
    hit(0, 0, 4'd0, 1'b0, 1'b1);
    drain("backpressure");

    // end-of-frame ordering and counter clear
    mode = 0;
    fdone();
    drain("eof_flush");
    hit(10, 20, 4'd2, 1'b0, 1'b1);
    hit(11, 21, 4'd4, 1'b0, 1'b1);
    hit(12, 22, 4'd6, 1'b0, 1'b1);
    fdone();
    drain("eof_three");
    fdone();
    drain("eof_zero");

    // coordinate saturation and hit coincident with frame_done
    hit(5, 9, 4'd7, 1'b0, 1'b1);
    hit(70000, 5, 4'd9, 1'b1, 1'b1);
    drain("sat_coinc");

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      mode = $urandom_range(0, 2);
      k = $urandom_range(0, 6);
      for (int h = 0; h < k; h++) begin
        bit last_fd;
        last_fd = (h == k - 1) && ($urandom_range(0, 2) == 0);
        hit(rnd_coord(), rnd_coord(), 4'($urandom_range(0, 15)),
            last_fd, 1'b1);
        idle($urandom_range(0, 3));
      end
      if (frame_hits != 0 || k == 0) fdone();
      drain("random");
    end

    // hit counter saturation
    mode = 0;
    for (int h = 0; h < 260; h++) begin
      hit(32'(h), 32'(h * 3), 4'(h), 1'b0, 1'b1);
      idle(8);
    end
    fdone();
    drain("count_sat");

    // overflow: one hit sits in the packet register, 16 fill the FIFO
    mode = 3;
    idle(2);
    for (int h = 0; h < 18; h++) begin
      hit(32'(100 + h), 32'(200 + h), 4'(h), 1'b0, h < 17);
    end
    chk("ovf_count", 32'(fifo_count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    mode = 0;
    drain("overflow");
    chk("ovf_sticky", 32'(overflow), 1);

    // reset in the middle of a packet
    mode = 4;
    tx_ready = 1'b1;
    hit(300, 400, 4'd5, 1'b0, 1'b1);
    hit(301, 401, 4'd6, 1'b0, 1'b1);
    base = acc_cnt;
    n = 0;
    while (acc_cnt - base < 2 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("rst_mid_bytes", 32'(acc_cnt - base), 2);
    reset_n = 1'b0;
    exp_q.delete();
    frame_hits = 0;
    @(posedge clock); #1;
    chk("rst_mid_valid", 32'(tx_valid), 0);
    chk("rst_mid_count", 32'(fifo_count), 0);
    chk("rst_mid_ovf", 32'(overflow), 0);
    chk("rst_mid_data", 32'(tx_data), 0);
    reset_n = 1'b1;
    mode = 0;
    idle(1);
    hit(37, 112, 4'd3, 1'b0, 1'b1);
    @(posedge clock); #1;
    chk("rst_new_header", 32'(tx_data), 32'hA5);
    drain("after_reset");
    fdone();
    drain("after_reset_eof");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
